sentry_victim_index_queue: RTL and testbench

Upstream feeder for the sentry DCache victim CAM. Accepts up to `SENTRY_WIDTH` parallel evictions per cycle and registers them onto the CAM write interface. Assigns each eviction the CAM slot index the CAM's internal write pointer will use, and stores that index in an in-order queue. Readback lanes pop indices in eviction order and receive a registered `victim_cam_index` to drive the CAM read ports.

---
 rtl/sentry_victim_index_queue.sv | 117 +++++++++++
 tb/tb_sentry_victim_index_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sentry_victim_index_queue.sv
// Feeds parallel cache evictions onto the victim CAM write port and keeps the
// allocated CAM slot indices in an in-order queue for the readback lanes.

`ifndef SENTRY_WIDTH
`define SENTRY_WIDTH 4
`endif

module sentry_victim_index_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int NLANES     = `SENTRY_WIDTH,
    parameter int LINE_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NLANES-1:0]                    evict_valid,
    input  logic [NLANES-1:0][LINE_WIDTH-1:0]    evict_line,
    output logic                                 evict_ready,
    output logic [NLANES-1:0]                    cache_evicted,
    output logic [NLANES-1:0][LINE_WIDTH-1:0]    cache_evict_line,
    input  logic [NLANES-1:0]                    pop_req,
    output logic [NLANES-1:0]                    pop_grant,
    output logic [NLANES-1:0][ADDR_WIDTH-1:0]    victim_cam_index,
    output logic [NLANES-1:0]                    victim_cam_valid,
    output logic [ADDR_WIDTH:0]                  occupancy,
    output logic                                 overflow_err
);

    localparam int MEMD  = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MEMD_C   = CNT_W'(MEMD);
    localparam logic [CNT_W-1:0] NLANES_C = CNT_W'(NLANES);

    logic [ADDR_WIDTH-1:0] mem [MEMD];
    logic [ADDR_WIDTH-1:0] alloc_ptr;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;

    logic [NLANES-1:0]                 accepted;
    logic [NLANES-1:0][ADDR_WIDTH-1:0] prefix;
    logic [NLANES-1:0][ADDR_WIDTH-1:0] alloc_idx;
    logic [NLANES-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [NLANES-1:0][ADDR_WIDTH-1:0] pop_idx;
    logic [CNT_W-1:0]                  valid_cnt;
    logic [CNT_W-1:0]                  push_cnt;
    logic [CNT_W-1:0]                  pop_cnt;
    logic                              run;

    // Room for a full group is judged from registered occupancy only.
    assign evict_ready = (MEMD_C - occupancy) >= NLANES_C;

    always_comb begin
        accepted  = evict_valid & {NLANES{evict_ready}};
        valid_cnt = '0;
        prefix    = '0;
        alloc_idx = '0;
        wr_addr   = '0;
        for (int i = 0; i < NLANES; i++) begin
            prefix[i]    = valid_cnt[ADDR_WIDTH-1:0];
            alloc_idx[i] = alloc_ptr + prefix[i];
            wr_addr[i]   = tail + prefix[i];
            valid_cnt    = valid_cnt + CNT_W'(evict_valid[i]);
        end
        push_cnt = evict_ready ? valid_cnt : '0;
    end

    // Grants are a thermometer code bounded by pre-cycle occupancy.
    always_comb begin
        run       = 1'b1;
        pop_cnt   = '0;
        pop_grant = '0;
        pop_idx   = '0;
        for (int i = 0; i < NLANES; i++) begin
            run          = run & pop_req[i];
            pop_grant[i] = run && (CNT_W'(i) < occupancy);
            pop_cnt      = pop_cnt + CNT_W'(pop_grant[i]);
            pop_idx[i]   = mem[head + ADDR_WIDTH'(i)];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANES; i++) begin
            if (accepted[i]) begin
                mem[wr_addr[i]] <= alloc_idx[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr        <= '0;
            head             <= '0;
            tail             <= '0;
            occupancy        <= '0;
            overflow_err     <= 1'b0;
            cache_evicted    <= '0;
            cache_evict_line <= '0;
            victim_cam_index <= '0;
            victim_cam_valid <= '0;
        end else begin
            alloc_ptr        <= alloc_ptr + push_cnt[ADDR_WIDTH-1:0];
            tail             <= tail + push_cnt[ADDR_WIDTH-1:0];
            head             <= head + pop_cnt[ADDR_WIDTH-1:0];
            occupancy        <= occupancy + push_cnt - pop_cnt;
            cache_evicted    <= accepted;
            cache_evict_line <= evict_line;
            victim_cam_valid <= pop_grant;
            for (int i = 0; i < NLANES; i++) begin
                victim_cam_index[i] <= pop_grant[i] ? pop_idx[i] : '0;
            end
            // A dropped group is remembered until the next reset.
            if ((|evict_valid) && !evict_ready) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sentry_victim_index_queue.sv
// Scoreboard bench for sentry_victim_index_queue: stimulus pushes expected CAM
// writes and readbacks, a negedge monitor pops them when the DUT presents output.

module tb_sentry_victim_index_queue;

   localparam int AW = 4;
   localparam int NL = 4;
   localparam int LW = 32;

   typedef struct {
      logic [NL-1:0]         mask;
      logic [NL-1:0][LW-1:0] lines;
   } wr_t;

   typedef struct {
      logic [NL-1:0]    mask;
      logic [NL*AW-1:0] idx;
   } rd_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NL-1:0]         evict_valid;
   logic [NL-1:0][LW-1:0] evict_line;
   logic                  evict_ready;
   logic [NL-1:0]         cache_evicted;
   logic [NL-1:0][LW-1:0] cache_evict_line;
   logic [NL-1:0]         pop_req;
   logic [NL-1:0]         pop_grant;
   logic [NL-1:0][AW-1:0] victim_cam_index;
   logic [NL-1:0]         victim_cam_valid;
   logic [AW:0]           occupancy;
   logic                  overflow_err;

   int  checks = 0;
   int  errors = 0;
   int  seq    = 0;
   wr_t wr_q[$];
   rd_t rd_q[$];

   sentry_victim_index_queue #(.ADDR_WIDTH(AW), .NLANES(NL), .LINE_WIDTH(LW)) dut (
      .clk              (clk),
      .rst              (rst),
      .evict_valid      (evict_valid),
      .evict_line       (evict_line),
      .evict_ready      (evict_ready),
      .cache_evicted    (cache_evicted),
      .cache_evict_line (cache_evict_line),
      .pop_req          (pop_req),
      .pop_grant        (pop_grant),
      .victim_cam_index (victim_cam_index),
      .victim_cam_valid (victim_cam_valid),
      .occupancy        (occupancy),
      .overflow_err     (overflow_err)
   );

   // Free-running clock, active edge at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Single comparison point shared by the stimulus thread and the monitor
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, check the combinational/status outputs before
   // the edge, and queue the registered responses the edge should produce
   task automatic applyStimulus(input logic [NL-1:0] ev, input logic [NL-1:0] pr,
                                input logic exp_ready, input logic [NL-1:0] exp_grant,
                                input logic [AW:0] exp_occ, input logic [NL*AW-1:0] exp_idx);
      wr_t w;
      rd_t r;
      @(negedge clk);
      seq++;
      evict_valid = ev;
      pop_req     = pr;
      for (int i = 0; i < NL; i++) evict_line[i] = 32'hC0DE0000 | 32'(seq * 16 + i);
      #1;
      checkOutput("evict_ready", 128'(evict_ready), 128'(exp_ready));
      checkOutput("pop_grant", 128'(pop_grant), 128'(exp_grant));
      checkOutput("occupancy", 128'(occupancy), 128'(exp_occ));
      if (ev != '0 && exp_ready) begin
         w.mask  = ev;
         w.lines = evict_line;
         wr_q.push_back(w);
      end
      if (exp_grant != '0) begin
         r.mask = exp_grant;
         r.idx  = exp_idx;
         rd_q.push_back(r);
      end
   endtask

   // Every output must be at its reset value; pop_req is held high to show
   // an empty queue grants nothing
   task automatic checkResetState();
      pop_req     = 4'b1111;
      evict_valid = '0;
      #1;
      checkOutput("rst_cache_evicted", 128'(cache_evicted), 128'(0));
      checkOutput("rst_cache_evict_line", 128'(cache_evict_line), 128'(0));
      checkOutput("rst_victim_cam_index", 128'(victim_cam_index), 128'(0));
      checkOutput("rst_victim_cam_valid", 128'(victim_cam_valid), 128'(0));
      checkOutput("rst_occupancy", 128'(occupancy), 128'(0));
      checkOutput("rst_overflow_err", 128'(overflow_err), 128'(0));
      checkOutput("rst_evict_ready", 128'(evict_ready), 128'(1));
      checkOutput("rst_pop_grant", 128'(pop_grant), 128'(0));
      pop_req = '0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst         = 1'b1;
      evict_valid = '0;
      pop_req     = '0;
      @(negedge clk);
      rst = 1'b0;
      checkResetState();
   endtask

   // Monitor: consume one expectation whenever the DUT presents a CAM write or readback
   always @(negedge clk) begin : monitor
      wr_t              w;
      rd_t              r;
      logic [NL*AW-1:0] m;
      if (cache_evicted != '0) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write got=%b required=none", cache_evicted);
         end else begin
            w = wr_q.pop_front();
            checkOutput("cache_evicted", 128'(cache_evicted), 128'(w.mask));
            checkOutput("cache_evict_line", 128'(cache_evict_line), 128'(w.lines));
         end
      end
      if (victim_cam_valid != '0) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_readback got=%b required=none", victim_cam_valid);
         end else begin
            r = rd_q.pop_front();
            for (int i = 0; i < NL; i++) m[i*AW +: AW] = {AW{r.mask[i]}};
            checkOutput("victim_cam_valid", 128'(victim_cam_valid), 128'(r.mask));
            checkOutput("victim_cam_index", 128'(victim_cam_index & m), 128'(r.idx & m));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [AW-1:0]    b;
      logic [NL*AW-1:0] idx;
      rst         = 1'b1;
      evict_valid = '0;
      pop_req     = '0;
      evict_line  = '0;
      doReset();

      // All-lane eviction then full readback
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1111, 5'd4, 16'h3210);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);

      // Sparse evictions keep prefix order; next allocation continues at 4
      doReset();
      applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b0000, 5'd2, 16'h0000);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1111, 5'd4, 16'h3210);
      applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0001, 5'd1, 16'h0004);

      // Thermometer grants: indices 5,6,7 queued
      applyStimulus(4'b0111, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b0000, 4'b1110, 1'b1, 4'b0000, 5'd3, 16'h0000);
      applyStimulus(4'b0000, 4'b1101, 1'b1, 4'b0001, 5'd3, 16'h0005);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0011, 5'd2, 16'h0076);

      // Fill to 13 (indices 8..15, 0..4), then a dropped group
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd4, 16'h0000);
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd8, 16'h0000);
      applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0000, 5'd12, 16'h0000);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 5'd13, 16'h0000);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd13, 16'h0000);
      checkOutput("overflow_err_set", 128'(overflow_err), 128'(1));
      applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd13, 16'h0000);
      checkOutput("overflow_err_sticky", 128'(overflow_err), 128'(1));

      // Drain across the wrap; dropped group must not have consumed index 5
      applyStimulus(4'b0000, 4'b1111, 1'b0, 4'b1111, 5'd13, 16'hBA98);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1111, 5'd9, 16'hFEDC);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1111, 5'd5, 16'h3210);
      applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0001, 5'd1, 16'h0004);
      applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0001, 5'd1, 16'h0005);
      checkOutput("overflow_err_hold", 128'(overflow_err), 128'(1));

      // Five full rounds from reset; fifth round wraps back to {3,2,1,0}
      doReset();
      for (int r = 0; r < 5; r++) begin
         b   = AW'(4 * r);
         idx = {b + 4'd3, b + 4'd2, b + 4'd1, b};
         applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
         applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1111, 5'd4, idx);
      end
      applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);

      // Push 4 / pop 2 at occupancy 6, then reset with a group in flight
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000, 5'd0, 16'h0000);
      applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0000, 5'd4, 16'h0000);
      applyStimulus(4'b1111, 4'b0011, 1'b1, 4'b0011, 5'd6, 16'h0054);
      @(negedge clk);
      rst         = 1'b1;
      evict_valid = 4'b1111;
      pop_req     = 4'b1111;
      #1;
      checkOutput("occupancy_push4_pop2", 128'(occupancy), 128'(8));
      @(negedge clk);
      rst = 1'b0;
      checkResetState();
      @(negedge clk);
      #1;
      checkOutput("write_queue_drained", 128'(wr_q.size()), 128'(0));
      checkOutput("read_queue_drained", 128'(rd_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
